// File: rtl/lsu_pkg.sv
// Shared state encoding and RISC-V funct3 size codes for the load/store unit controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU: store mask and data shift, legality checks
// and load data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic        misaligned,
  output logic        illegal,
  output logic [31:0] load_data
);

  logic [31:0] rdata_sh;

  assign wdata_sh = wdata << {addr_lo, 3'b000};
  assign rdata_sh = rdata >> {addr_lo, 3'b000};

  // Size is carried in funct3[1:0]; illegal codes are flagged separately.
  always_comb begin
    misaligned = 1'b0;
    if (is_load || is_store) begin
      case (funct3[1:0])
        2'd1:    misaligned = addr_lo[0];
        2'd2:    misaligned = (addr_lo != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end

  always_comb begin
    illegal = 1'b0;
    if (is_load)
      illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    else if (is_store)
      illegal = (funct3 >= 3'd3);
  end

  always_comb begin
    wmask = 4'b0000;
    if (is_store) begin
      case (funct3)
        F3_B:    wmask = 4'b0001 << addr_lo;
        F3_H:    wmask = 4'b0011 << addr_lo;
        F3_W:    wmask = 4'b1111;
        default: wmask = 4'b0000;
      endcase
    end
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      F3_BU:   load_data = {24'h0, rdata_sh[7:0]};
      F3_H:    load_data = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      F3_HU:   load_data = {16'h0, rdata_sh[15:0]};
      F3_W:    load_data = rdata_sh;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: takes one op from the EXU, runs a single memory
// request/response and hands the extended result to the WBU.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        lsu_reqValid,
  output logic [31:0] lsu_addr,
  output logic        lsu_wen,
  output logic [31:0] lsu_wdata,
  output logic [3:0]  lsu_wmask,
  input  logic        lsu_respValid,
  input  logic [31:0] lsu_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state;
  logic [7:0]  cnt;
  logic        is_load_q, is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [4:0]  rd_q;
  logic        wen_q, err_q;

  logic        idle, in_req, in_resp, accept, op_err;
  logic        op_is_load, op_is_store;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata;
  logic [3:0]  wmask;
  logic [31:0] wdata_sh, load_data;
  logic        misaligned, illegal;

  assign idle    = (state == IDLE);
  assign in_req  = (state == REQ);
  assign in_resp = (state == RESP);

  assign in_ready = idle && !rst;
  assign accept   = in_valid && in_ready;

  // The aligner checks the incoming op while idle and the registered op afterwards.
  assign op_is_load  = idle ? in_is_load  : is_load_q;
  assign op_is_store = idle ? in_is_store : is_store_q;
  assign op_funct3   = idle ? in_funct3   : funct3_q;
  assign op_addr     = idle ? in_addr     : addr_q;
  assign op_wdata    = idle ? in_wdata    : wdata_q;
  assign op_err      = (op_is_load || op_is_store) && (misaligned || illegal);

  lsu_align u_align (
    .is_load    (op_is_load),
    .is_store   (op_is_store),
    .funct3     (op_funct3),
    .addr_lo    (op_addr[1:0]),
    .wdata      (op_wdata),
    .rdata      (lsu_rdata),
    .wmask      (wmask),
    .wdata_sh   (wdata_sh),
    .misaligned (misaligned),
    .illegal    (illegal),
    .load_data  (load_data)
  );

  assign lsu_reqValid = in_req;
  assign lsu_addr     = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign lsu_wen      = in_req && is_store_q;
  assign lsu_wdata    = in_req ? wdata_sh : 32'h0;
  assign lsu_wmask    = in_req ? wmask : 4'b0000;

  assign out_valid = in_resp;
  assign out_rdata = in_resp ? rdata_q : 32'h0;
  assign out_rd    = in_resp ? rd_q : 5'd0;
  assign out_wen   = in_resp && wen_q;
  assign out_err   = in_resp && err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rd_q       <= 5'd0;
      rdata_q    <= 32'h0;
      wen_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          is_load_q  <= in_is_load;
          is_store_q <= in_is_store;
          funct3_q   <= in_funct3;
          addr_q     <= in_addr;
          wdata_q    <= in_wdata;
          rd_q       <= in_rd;
          rdata_q    <= 32'h0;
          wen_q      <= 1'b0;
          cnt        <= 8'd0;
          err_q      <= op_err;
          state      <= (op_err || !(in_is_load || in_is_store)) ? RESP : REQ;
        end
        REQ: begin
          cnt   <= 8'd0;
          state <= WAIT;
        end
        // A response in the final counted cycle still wins over the timeout.
        WAIT: if (lsu_respValid) begin
          rdata_q <= is_load_q ? load_data : 32'h0;
          wen_q   <= is_load_q && (rd_q != 5'd0);
          state   <= RESP;
        end else if (cnt == CNT_LAST) begin
          err_q <= 1'b1;
          wen_q <= 1'b0;
          state <= RESP;
        end else begin
          cnt <= cnt + 8'd1;
        end
        RESP: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
